// File: rtl/dbginit_seq_pkg.sv
// Shared types and width helpers for the DBGINIT regression sequencer.
package dbginit_seq_pkg;

   localparam int unsigned CNT_W = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_SETTLE,
      ST_CHECK,
      ST_REPORT,
      ST_DONE
   } seq_state_e;

   function automatic int unsigned MON_ID_W(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned ROUND_W(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dbginit_fail_pick.sv
// Find-first-set over a failure vector: lowest set index plus an any flag.
module dbginit_fail_pick #(
   parameter int unsigned N    = 8,
   parameter int unsigned ID_W = 3
) (
   input  logic [N-1:0]    vec,
   output logic [ID_W-1:0] idx_c,
   output logic            any_c
);

   // Scan high to low so the lowest set bit wins.
   always_comb begin
      idx_c = '0;
      any_c = |vec;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx_c = ID_W'(i);
      end
   end

endmodule

// File: rtl/dbginit_seq_ctrl.sv
// DBGINIT pulse/settle/check sequencer with failing-monitor report drain.
// Build option: DBGINIT_SEQ_ABORT_EN ends the run after the first failing round.
module dbginit_seq_ctrl
   import dbginit_seq_pkg::*;
#(
   parameter int unsigned NUM_MON    = 8,
   parameter int unsigned ASSERT_CYC = 16,
   parameter int unsigned NUM_ROUNDS = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [10:0]                     settle_cyc,
   output logic                            dbginit,
   output logic                            check_en,
   input  logic [NUM_MON-1:0]              mon_fail,
   output logic                            rpt_valid,
   input  logic                            rpt_ready,
   output logic [MON_ID_W(NUM_MON)-1:0]    rpt_id,
   output logic [ROUND_W(NUM_ROUNDS)-1:0]  rpt_round,
   output logic                            busy,
   output logic                            done,
   output logic                            fail
);

   localparam int unsigned ID_W  = MON_ID_W(NUM_MON);
   localparam int unsigned RND_W = ROUND_W(NUM_ROUNDS);

   seq_state_e         state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   settle_q;
   logic [RND_W-1:0]   round;
   logic [NUM_MON-1:0] fail_vec;
   logic [NUM_MON-1:0] vec_clr;
   logic [NUM_MON-1:0] pick_in;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic               hs_c;
   logic               round_end_c;
   logic               to_done_c;

   // Picker sees fresh flags in CHECK, otherwise the vector minus the beat being accepted.
   always_comb begin
      vec_clr = fail_vec & ~(NUM_MON'(1) << rpt_id);
      pick_in = (state == ST_CHECK) ? mon_fail : vec_clr;
   end

   dbginit_fail_pick #(
      .N    (NUM_MON),
      .ID_W (ID_W)
   ) u_pick (
      .vec   (pick_in),
      .idx_c (pick_idx),
      .any_c (pick_any)
   );

   assign hs_c        = rpt_valid & rpt_ready;
   assign round_end_c = ((state == ST_CHECK) || ((state == ST_REPORT) && hs_c)) && !pick_any;
`ifdef DBGINIT_SEQ_ABORT_EN
   assign to_done_c   = (round == RND_W'(NUM_ROUNDS - 1)) || (state == ST_REPORT);
`else
   assign to_done_c   = (round == RND_W'(NUM_ROUNDS - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         settle_q  <= '0;
         round     <= '0;
         fail_vec  <= '0;
         dbginit   <= 1'b0;
         check_en  <= 1'b0;
         rpt_valid <= 1'b0;
         rpt_id    <= '0;
         rpt_round <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
      end else begin
         done     <= 1'b0;
         check_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  settle_q <= settle_cyc;
                  round    <= '0;
                  fail     <= 1'b0;
                  cnt      <= '0;
                  dbginit  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_ASSERT;
               end
            end
            ST_ASSERT: begin
               if (cnt == CNT_W'(ASSERT_CYC - 1)) begin
                  dbginit <= 1'b0;
                  cnt     <= '0;
                  if (settle_q == '0) begin
                     check_en <= 1'b1;
                     state    <= ST_CHECK;
                  end else begin
                     state    <= ST_SETTLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_SETTLE: begin
               if (cnt == settle_q - CNT_W'(1)) begin
                  check_en <= 1'b1;
                  state    <= ST_CHECK;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_CHECK: begin
               fail_vec <= mon_fail;
               if (pick_any) begin
                  fail      <= 1'b1;
                  rpt_valid <= 1'b1;
                  rpt_id    <= pick_idx;
                  rpt_round <= round;
                  state     <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               if (hs_c) begin
                  fail_vec <= vec_clr;
                  if (pick_any) rpt_id <= pick_idx;
                  else          rpt_valid <= 1'b0;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // Shared round-end decision for clean CHECK and drained REPORT.
         if (round_end_c) begin
            if (to_done_c) begin
               done  <= 1'b1;
               state <= ST_DONE;
            end else begin
               round   <= round + RND_W'(1);
               cnt     <= '0;
               dbginit <= 1'b1;
               state   <= ST_ASSERT;
            end
         end
      end
   end

endmodule

// File: tb/tb_dbginit_seq_ctrl.sv
// Randomized self-checking bench for dbginit_seq_ctrl against a timeline model.
module tb_dbginit_seq_ctrl;

   localparam int unsigned NM = 4;
   localparam int unsigned AC = 4;
   localparam int unsigned NR = 2;
`ifdef DBGINIT_SEQ_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [10:0]   settle_cyc;
   logic          dbginit;
   logic          check_en;
   logic [NM-1:0] mon_fail;
   logic          rpt_valid;
   logic          rpt_ready;
   logic [1:0]    rpt_id;
   logic [0:0]    rpt_round;
   logic          busy;
   logic          done;
   logic          fail;

   int n_tests = 0;
   int n_fail  = 0;
   logic fail_exp = 1'b0;

   always #5 clk = ~clk;

   dbginit_seq_ctrl #(
      .NUM_MON    (NM),
      .ASSERT_CYC (AC),
      .NUM_ROUNDS (NR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .settle_cyc (settle_cyc),
      .dbginit    (dbginit),
      .check_en   (check_en),
      .mon_fail   (mon_fail),
      .rpt_valid  (rpt_valid),
      .rpt_ready  (rpt_ready),
      .rpt_id     (rpt_id),
      .rpt_round  (rpt_round),
      .busy       (busy),
      .done       (done),
      .fail       (fail)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".dbginit"},   32'(dbginit),   32'(0));
      chk({tag, ".check_en"},  32'(check_en),  32'(0));
      chk({tag, ".rpt_valid"}, 32'(rpt_valid), 32'(0));
      chk({tag, ".busy"},      32'(busy),      32'(0));
      chk({tag, ".done"},      32'(done),      32'(0));
      chk({tag, ".fail"},      32'(fail),      32'(fail_exp));
   endtask

   // Timeline model: round k starts at cycle b; dbginit on b+1..b+AC, check at b+AC+s+1,
   // then one report beat per failing bit (lowest first) until each is accepted.
   task automatic run_seq(input logic [10:0] s, input logic [NM-1:0] f0, input logic [NM-1:0] f1,
                          input bit stall5, input bit poke_start);
      logic [NM-1:0] fv [NR];
      int            q [$];
      int            st;
      int            pc;
      logic          rdy;
      fv[0] = f0;
      fv[1] = f1;
      start      = 1'b1;
      settle_cyc = s;
      tick();
      start      = 1'b0;
      settle_cyc = 11'($urandom);
      fail_exp   = 1'b0;
      for (int r = 0; r < int'(NR); r++) begin
         for (int t = 1; t <= int'(AC) + int'(s); t++) begin
            start     = (poke_start && t == 2);
            mon_fail  = NM'($urandom);
            rpt_ready = 1'($urandom);
            chk("run.dbginit",   32'(dbginit),   32'(t <= int'(AC)));
            chk("run.check_en",  32'(check_en),  32'(0));
            chk("run.rpt_valid", 32'(rpt_valid), 32'(0));
            chk("run.busy",      32'(busy),      32'(1));
            chk("run.done",      32'(done),      32'(0));
            chk("run.fail",      32'(fail),      32'(fail_exp));
            tick();
         end
         start = 1'b0;
         chk("chk.check_en",  32'(check_en),  32'(1));
         chk("chk.dbginit",   32'(dbginit),   32'(0));
         chk("chk.rpt_valid", 32'(rpt_valid), 32'(0));
         chk("chk.busy",      32'(busy),      32'(1));
         mon_fail = fv[r];
         tick();
         mon_fail = NM'($urandom);
         q.delete();
         for (int i = 0; i < int'(NM); i++) if (fv[r][i]) q.push_back(i);
         if (q.size() != 0) fail_exp = 1'b1;
         st = 0;
         pc = 0;
         while (q.size() != 0) begin
            if (stall5 && pc < 5) rdy = 1'b0;
            else if (st >= 8)     rdy = 1'b1;
            else                  rdy = 1'($urandom);
            rpt_ready = rdy;
            chk("rpt.valid",    32'(rpt_valid), 32'(1));
            chk("rpt.id",       32'(rpt_id),    32'(q[0]));
            chk("rpt.round",    32'(rpt_round), 32'(r));
            chk("rpt.check_en", 32'(check_en),  32'(0));
            chk("rpt.dbginit",  32'(dbginit),   32'(0));
            chk("rpt.fail",     32'(fail),      32'(1));
            tick();
            if (rdy) begin
               void'(q.pop_front());
               st = 0;
            end else begin
               st++;
            end
            pc++;
         end
         rpt_ready = 1'($urandom);
         if (r == int'(NR) - 1 || (ABORT && fv[r] != '0)) break;
      end
      chk("done.done",      32'(done),      32'(1));
      chk("done.busy",      32'(busy),      32'(1));
      chk("done.dbginit",   32'(dbginit),   32'(0));
      chk("done.rpt_valid", 32'(rpt_valid), 32'(0));
      chk("done.fail",      32'(fail),      32'(fail_exp));
      tick();
      chk_idle("post");
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         start     = 1'b0;
         mon_fail  = NM'($urandom);
         rpt_ready = 1'($urandom);
         tick();
         chk_idle("gap");
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      settle_cyc = '0;
      mon_fail   = '0;
      rpt_ready  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk_idle("reset");
      chk("reset.rpt_id",    32'(rpt_id),    32'(0));
      chk("reset.rpt_round", 32'(rpt_round), 32'(0));

      run_seq(11'd3, 4'b0000, 4'b0000, 1'b0, 1'b0);
      idle_gap(1);
      run_seq(11'd3, 4'b1010, 4'b0000, 1'b0, 1'b0);
      idle_gap(2);
      run_seq(11'd2, 4'b0110, 4'b1001, 1'b1, 1'b0);
      idle_gap(1);
      run_seq(11'd0, 4'b0000, 4'b0001, 1'b0, 1'b1);

      // Reset while settling, then a fresh full run.
      start      = 1'b1;
      settle_cyc = 11'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < int'(AC) + 1; i++) tick();
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      fail_exp = 1'b0;
      chk_idle("midrst");
      chk("midrst.rpt_id",    32'(rpt_id),    32'(0));
      chk("midrst.rpt_round", 32'(rpt_round), 32'(0));
      idle_gap(1);
      run_seq(11'd3, 4'b0100, 4'b0000, 1'b0, 1'b0);

      for (int k = 0; k < 8; k++) begin
         idle_gap(int'($urandom_range(0, 2)));
         run_seq(11'($urandom_range(0, 6)), NM'($urandom & $urandom), NM'($urandom & $urandom),
                 1'($urandom), 1'($urandom));
      end

      idle_gap(1);
      run_seq(11'd2047, 4'b0000, 4'b1111, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
